// File: rtl/ex_mul_div_unit.sv
// RV32M multiply/divide unit for the EX stage: two-cycle multiplies and
// special cases, 33-cycle radix-2 restoring division, busy/done handshake.
`timescale 1ns/1ps

module ex_mul_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    output logic [31:0] result,
    output logic        busy,
    output logic        done
);

    localparam int unsigned XLEN      = 32;
    localparam int unsigned CNT_W     = 6;
    localparam int unsigned DIV_STEPS = 32;

    localparam logic [2:0] OP_MUL = 3'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_e;

    state_e            state_q;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic [XLEN:0]     rem_q;
    logic [XLEN-1:0]   quo_q;
    logic [CNT_W-1:0]  count_q;
    logic              q_neg_q;
    logic              r_neg_q;
    logic [XLEN-1:0]   result_q;

    // Accept-time decode of the incoming request
    logic              div_signed_c;
    logic              div_zero_c;
    logic              div_ovf_c;
    logic              slow_div_c;
    logic [XLEN-1:0]   a_mag_c;
    logic [XLEN-1:0]   b_mag_c;

    always_comb begin
        div_signed_c = op[2] & ~op[0];
        div_zero_c   = (operand2 == '0);
        div_ovf_c    = div_signed_c && (operand1 == 32'h8000_0000)
                                    && (operand2 == 32'hFFFF_FFFF);
        slow_div_c   = op[2] & ~div_zero_c & ~div_ovf_c;
        a_mag_c      = (div_signed_c && operand1[XLEN-1]) ? XLEN'(-operand1) : operand1;
        b_mag_c      = (div_signed_c && operand2[XLEN-1]) ? XLEN'(-operand2) : operand2;
    end

    // Multiply datapath; the low 64 bits of a 64-bit product of the
    // sign/zero-extended operands are exact for every signedness mix.
    logic                 mul_a_signed_c;
    logic                 mul_b_signed_c;
    logic signed [XLEN:0] mul_a_ext_c;
    logic signed [XLEN:0] mul_b_ext_c;
    logic [2*XLEN-1:0]    prod_c;
    logic [XLEN-1:0]      mul_result_c;
    logic [XLEN-1:0]      fast_result_c;

    always_comb begin
        mul_a_signed_c = ~op_q[2] & (op_q[1:0] != 2'b11);
        mul_b_signed_c = ~op_q[2] & ~op_q[1];
        mul_a_ext_c    = {mul_a_signed_c & a_q[XLEN-1], a_q};
        mul_b_ext_c    = {mul_b_signed_c & b_q[XLEN-1], b_q};
        prod_c         = 64'(mul_a_ext_c) * 64'(mul_b_ext_c);
        mul_result_c   = (op_q == OP_MUL) ? prod_c[XLEN-1:0] : prod_c[2*XLEN-1:XLEN];
        // Div/rem ops only reach S_MUL via divide-by-zero or signed overflow
        if (b_q == '0) begin
            fast_result_c = op_q[1] ? a_q : 32'hFFFF_FFFF;
        end else begin
            fast_result_c = op_q[1] ? 32'h0000_0000 : 32'h8000_0000;
        end
    end

    // One restoring-division step: shift in the next dividend bit, trial subtract
    logic [XLEN+1:0] diff_c;
    logic            ge_c;
    logic [XLEN:0]   rem_d;
    logic [XLEN-1:0] quo_d;
    logic [XLEN-1:0] q_fix_c;
    logic [XLEN-1:0] r_fix_c;
    logic [XLEN-1:0] div_result_c;

    always_comb begin
        diff_c       = {rem_q, quo_q[XLEN-1]} - {2'b00, b_q};
        ge_c         = ~diff_c[XLEN+1];
        rem_d        = ge_c ? diff_c[XLEN:0] : {rem_q[XLEN-1:0], quo_q[XLEN-1]};
        quo_d        = {quo_q[XLEN-2:0], ge_c};
        q_fix_c      = q_neg_q ? XLEN'(-quo_d) : quo_d;
        r_fix_c      = r_neg_q ? XLEN'(-rem_d[XLEN-1:0]) : rem_d[XLEN-1:0];
        div_result_c = op_q[1] ? r_fix_c : q_fix_c;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            count_q  <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        op_q    <= op;
                        a_q     <= operand1;
                        b_q     <= slow_div_c ? b_mag_c : operand2;
                        quo_q   <= slow_div_c ? a_mag_c : '0;
                        rem_q   <= '0;
                        q_neg_q <= div_signed_c & (operand1[XLEN-1] ^ operand2[XLEN-1]);
                        r_neg_q <= div_signed_c & operand1[XLEN-1];
                        if (slow_div_c) begin
                            count_q <= CNT_W'(DIV_STEPS);
                            state_q <= S_DIV;
                        end else begin
                            state_q <= S_MUL;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_MUL: begin
                    result_q <= op_q[2] ? fast_result_c : mul_result_c;
                    state_q  <= S_DONE;
                end
                S_DIV: begin
                    rem_q   <= rem_d;
                    quo_q   <= quo_d;
                    count_q <= count_q - CNT_W'(1);
                    if (count_q == CNT_W'(1)) begin
                        result_q <= div_result_c;
                        state_q  <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign result = result_q;
    assign busy   = (state_q == S_MUL) || (state_q == S_DIV);
    assign done   = (state_q == S_DONE);

endmodule

// File: tb/tb_ex_mul_div_unit.sv
// Self-checking bench for ex_mul_div_unit: directed corner cases plus random
// operations checked against an arithmetic reference model.
`timescale 1ns/1ps

module tb_ex_mul_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [31:0] result;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;

    ex_mul_div_unit dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .operand1 (operand1),
        .operand2 (operand2),
        .result   (result),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // RISC-V M-extension semantics computed with 64-bit integer arithmetic
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ua;
        longint      ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (o)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
            3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            default: begin if (b == 0) return a; return a % b; end
        endcase
    endfunction

    // Edges from the accepting edge to the one that registers the result
    function automatic int exp_edges(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o < 3'd4 || b == 0) return 1;
        if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 32;
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input bit chain, input int inject);
        logic [31:0] exp;
        int          edges;
        int          n;
        int          busy_cnt;
        bit          got;
        exp   = model(o, a, b);
        edges = exp_edges(o, a, b);
        @(negedge clk);
        start = 1'b1; op = o; operand1 = a; operand2 = b;
        @(posedge clk); #1;
        start = 1'b0; op = 3'($urandom); operand1 = $urandom; operand2 = $urandom;
        busy_cnt = busy ? 1 : 0;
        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            if (n == inject) begin
                start = 1'b1; op = 3'($urandom); operand1 = $urandom; operand2 = $urandom;
            end
            @(posedge clk); #1;
            start = 1'b0;
            n++;
            if (done) got = 1'b1;
            else if (busy) busy_cnt++;
        end
        check({tag, " done_seen"}, 32'(got), 32'd1);
        check({tag, " latency"}, 32'(n), 32'(edges));
        check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(edges));
        check({tag, " result"}, result, exp);
        if (!chain) begin
            @(posedge clk); #1;
            check({tag, " done_pulse"}, 32'(done), 32'd0);
            check({tag, " idle_busy"}, 32'(busy), 32'd0);
            check({tag, " hold"}, result, exp);
        end
    endtask

    initial begin
        bit          saw;
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        reset = 1'b1; start = 1'b0; op = '0; operand1 = '0; operand2 = '0;
        #1;
        check("reset result", result, 32'h0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        run_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0, -1);
        run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1);
        run_op("mulhsu_m1", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1);
        run_op("div_neg7", 3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0, -1);
        run_op("rem_neg7", 3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0, -1);
        run_op("divu_by0", 3'd5, 32'd5, 32'd0, 1'b0, -1);
        run_op("remu_by0", 3'd7, 32'd5, 32'd0, 1'b0, -1);
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1);
        run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1);
        run_op("div_ignored_start", 3'd4, 32'd1000, 32'hFFFF_FFFD, 1'b0, 5);

        // Start issued in the DONE cycle is accepted without an idle bubble
        run_op("divu_chain", 3'd5, 32'd100, 32'd7, 1'b1, -1);
        start = 1'b1; op = 3'd0; operand1 = 32'd7; operand2 = 32'd6;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b done_drop", 32'(done), 32'd0);
        check("b2b busy_rise", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check("b2b done", 32'(done), 32'd1);
        check("b2b result", result, 32'h0000_002A);

        // Asynchronous reset in the middle of a division
        @(negedge clk);
        start = 1'b1; op = 3'd5; operand1 = 32'd123456; operand2 = 32'd789;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midreset result", result, 32'h0);
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        saw = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) saw = 1'b1;
        end
        check("midreset no_done", 32'(saw), 32'd0);
        run_op("mul_after_reset", 3'd0, 32'd3, 32'd4, 1'b0, -1);

        for (int i = 0; i < 60; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = rnd_operand();
            rb = rnd_operand();
            run_op($sformatf("rnd%0d op%0d %h %h", i, ro, ra, rb), ro, ra, rb, 1'b0, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
